// File: rtl/k12a_io_bank_if.sv
// CPU I/O strobe bus for the K12A I/O bank: load/store strobes, a 4-bit
// register address, and separate write and read data buses.
interface k12a_io_bank_if;
    logic       io_load;
    logic       io_store;
    logic [3:0] io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;

    // CPU side: drives strobes, address and write data, receives read data.
    modport master (
        output io_load,
        output io_store,
        output io_addr,
        output io_wdata,
        input  io_rdata
    );

    // I/O bank side: receives strobes, address and write data, returns read data.
    modport slave (
        input  io_load,
        input  io_store,
        input  io_addr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/k12a_io_bank.sv
// K12A memory-mapped I/O bank: byte-wide GPIO out/in ports (inputs double-flop
// synchronised), a mode-0 MSB-first SPI master with programmable half-period
// divider, and a maskable edge-triggered wake latch cleared by write-1.
// Optional build macro K12A_IO_SPI_LOOPBACK_EN adds CTRL bit0 "loopback",
// which routes the internal spi_mosi into the receive shifter.
module k12a_io_bank #(
    parameter int N_GPIO    = 3,
    parameter int WAKE_W    = 8,
    parameter int SPI_DIV_W = 8
) (
    input  logic                  cpu_clock,
    input  logic                  reset,
    k12a_io_bank_if.slave         bus,
    output logic [8*N_GPIO-1:0]   gpio_out,
    input  logic [8*N_GPIO-1:0]   gpio_in,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    input  logic [WAKE_W-1:0]     wake_sources,
    output logic                  wake
);

    localparam logic [3:0] ADDR_CTRL      = 4'h8;
    localparam logic [3:0] ADDR_SPI_DATA  = 4'h9;
    localparam logic [3:0] ADDR_STATUS    = 4'hA;
    localparam logic [3:0] ADDR_WAKE_MASK = 4'hB;
    localparam logic [3:0] ADDR_SPI_DIV   = 4'hC;
    localparam logic [SPI_DIV_W-1:0] DIV_ONE = SPI_DIV_W'(1);

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_LEAD  = 2'd1,
        SPI_TRAIL = 2'd2
    } spi_state_t;

    // Architectural and synchroniser state
    logic [8*N_GPIO-1:0]  gpio_out_q, gpio_out_d;
    logic [8*N_GPIO-1:0]  gin_s1_q, gin_s2_q;
    logic [WAKE_W-1:0]    wake_mask_q, wake_mask_d;
    logic [WAKE_W-1:0]    wk_s1_q, wk_s2_q, wk_prev_q;
    logic                 wake_pending_q, wake_pending_d;
    logic [SPI_DIV_W-1:0] spi_div_q, spi_div_d;
    logic                 miso_s1_q, miso_s2_q;

    // SPI engine state
    spi_state_t           state_q;
    logic [SPI_DIV_W-1:0] div_act_q;
    logic [SPI_DIV_W-1:0] cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           tx_q;
    logic [7:0]           rx_shift_q;
    logic [7:0]           rx_data_q;
    logic                 sck_q;
    logic                 mosi_q;

    // Decoded strobes and helpers
    logic       busy_s;
    logic       spi_data_wr_s;
    logic       wake_edge_s;
    logic       w1c_s;
    logic       rx_bit_s;
    logic [7:0] ctrl_rd_s;
    logic [7:0] rdata_s;

    assign busy_s        = (state_q != SPI_IDLE);
    assign spi_data_wr_s = bus.io_store && (bus.io_addr == ADDR_SPI_DATA) && !busy_s;
    assign wake_edge_s   = |(wk_s2_q & ~wk_prev_q & wake_mask_q);
    assign w1c_s         = bus.io_store && (bus.io_addr == ADDR_STATUS) && bus.io_wdata[1];

`ifdef K12A_IO_SPI_LOOPBACK_EN
    logic loopback_q;

    // Loopback control bit, written through CTRL bit0.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            loopback_q <= 1'b0;
        end else if (bus.io_store && (bus.io_addr == ADDR_CTRL)) begin
            loopback_q <= bus.io_wdata[0];
        end else begin
            loopback_q <= loopback_q;
        end
    end

    assign rx_bit_s  = loopback_q ? mosi_q : miso_s2_q;
    assign ctrl_rd_s = {7'b000_0000, loopback_q};
`else
    assign rx_bit_s  = miso_s2_q;
    assign ctrl_rd_s = 8'h00;
`endif

    // Next-state for the CPU-writable registers and the wake latch.
    always_comb begin
        gpio_out_d = gpio_out_q;
        for (int k = 0; k < N_GPIO; k++) begin
            gpio_out_d[8*k +: 8] = (bus.io_store && (bus.io_addr == 4'(k)))
                                   ? bus.io_wdata : gpio_out_q[8*k +: 8];
        end
        wake_mask_d = (bus.io_store && (bus.io_addr == ADDR_WAKE_MASK))
                      ? bus.io_wdata[WAKE_W-1:0] : wake_mask_q;
        spi_div_d   = (bus.io_store && (bus.io_addr == ADDR_SPI_DIV) && !busy_s)
                      ? bus.io_wdata[SPI_DIV_W-1:0] : spi_div_q;
        // A new edge in the same cycle as a W1C keeps the latch set.
        if (wake_edge_s) begin
            wake_pending_d = 1'b1;
        end else if (w1c_s) begin
            wake_pending_d = 1'b0;
        end else begin
            wake_pending_d = wake_pending_q;
        end
    end

    // Register file, input synchronisers and wake edge detector.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            gpio_out_q     <= '0;
            gin_s1_q       <= '0;
            gin_s2_q       <= '0;
            wake_mask_q    <= '0;
            wk_s1_q        <= '0;
            wk_s2_q        <= '0;
            wk_prev_q      <= '0;
            wake_pending_q <= 1'b0;
            spi_div_q      <= '0;
            miso_s1_q      <= 1'b0;
            miso_s2_q      <= 1'b0;
        end else begin
            gpio_out_q     <= gpio_out_d;
            gin_s1_q       <= gpio_in;
            gin_s2_q       <= gin_s1_q;
            wake_mask_q    <= wake_mask_d;
            wk_s1_q        <= wake_sources;
            wk_s2_q        <= wk_s1_q;
            wk_prev_q      <= wk_s2_q;
            wake_pending_q <= wake_pending_d;
            spi_div_q      <= spi_div_d;
            miso_s1_q      <= spi_miso;
            miso_s2_q      <= miso_s1_q;
        end
    end

    // SPI mode-0 engine: LEAD half ends with sck rising and an rx sample,
    // TRAIL half ends with sck falling and the next tx bit on mosi.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state_q    <= SPI_IDLE;
            div_act_q  <= '0;
            cnt_q      <= '0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            case (state_q)
                SPI_IDLE: begin
                    sck_q <= 1'b0;
                    if (spi_data_wr_s) begin
                        tx_q      <= bus.io_wdata;
                        mosi_q    <= bus.io_wdata[7];
                        div_act_q <= spi_div_q;
                        cnt_q     <= '0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= SPI_LEAD;
                    end else begin
                        state_q   <= SPI_IDLE;
                    end
                end
                SPI_LEAD: begin
                    if (cnt_q == div_act_q) begin
                        sck_q      <= 1'b1;
                        rx_shift_q <= {rx_shift_q[6:0], rx_bit_s};
                        cnt_q      <= '0;
                        state_q    <= SPI_TRAIL;
                    end else begin
                        cnt_q      <= cnt_q + DIV_ONE;
                    end
                end
                SPI_TRAIL: begin
                    if (cnt_q == div_act_q) begin
                        sck_q  <= 1'b0;
                        tx_q   <= {tx_q[6:0], 1'b0};
                        mosi_q <= tx_q[6];
                        cnt_q  <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q <= rx_shift_q;
                            state_q   <= SPI_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            state_q   <= SPI_LEAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_ONE;
                    end
                end
                default: begin
                    sck_q   <= 1'b0;
                    state_q <= SPI_IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; unimplemented ports and addresses read zero.
    always_comb begin
        rdata_s = 8'h00;
        if (bus.io_load) begin
            case (bus.io_addr)
                4'h0, 4'h1, 4'h2, 4'h3: begin
                    for (int k = 0; k < N_GPIO; k++) begin
                        rdata_s = rdata_s | ((bus.io_addr[1:0] == 2'(k))
                                  ? gpio_out_q[8*k +: 8] : 8'h00);
                    end
                end
                4'h4, 4'h5, 4'h6, 4'h7: begin
                    for (int k = 0; k < N_GPIO; k++) begin
                        rdata_s = rdata_s | ((bus.io_addr[1:0] == 2'(k))
                                  ? gin_s2_q[8*k +: 8] : 8'h00);
                    end
                end
                ADDR_CTRL:      rdata_s = ctrl_rd_s;
                ADDR_SPI_DATA:  rdata_s = rx_data_q;
                ADDR_STATUS:    rdata_s = {6'b00_0000, wake_pending_q, busy_s};
                ADDR_WAKE_MASK: rdata_s = 8'(wake_mask_q);
                ADDR_SPI_DIV:   rdata_s = 8'(spi_div_q);
                default:        rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign bus.io_rdata = rdata_s;
    assign gpio_out     = gpio_out_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign wake         = wake_pending_q;

endmodule

// File: tb/tb_k12a_io_bank.sv
// Directed self-checking bench for k12a_io_bank (default parameters).
module tb_k12a_io_bank;

    logic        cpu_clock;
    logic        reset;
    logic [23:0] gpio_out;
    logic [23:0] gpio_in;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  wake_sources;
    logic        wake;

    int total = 0;
    int bad   = 0;

    k12a_io_bank_if bus ();

    k12a_io_bank #(.N_GPIO(3), .WAKE_W(8), .SPI_DIV_W(8)) dut (
        .cpu_clock    (cpu_clock),
        .reset        (reset),
        .bus          (bus),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .wake_sources (wake_sources),
        .wake         (wake)
    );

    initial begin
        cpu_clock = 1'b0;
        forever #5 cpu_clock = ~cpu_clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.io_store = 1'b1;
        bus.io_addr  = a;
        bus.io_wdata = d;
        tick();
        bus.io_store = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.io_load = 1'b1;
        bus.io_addr = a;
        #1;
        d = bus.io_rdata;
        bus.io_load = 1'b0;
    endtask

`ifdef K12A_IO_SPI_LOOPBACK_EN
    localparam logic [7:0] EXP_CTRL = 8'h01;
    localparam logic [7:0] EXP_LB   = 8'hC3;
`else
    localparam logic [7:0] EXP_CTRL = 8'h00;
    localparam logic [7:0] EXP_LB   = 8'h00;
`endif

    initial begin
        logic [7:0] d;
        logic [7:0] tx_pat;
        logic [7:0] rx_pat;
        tx_pat = 8'h96;
        rx_pat = 8'h5A;

        reset        = 1'b1;
        bus.io_load  = 1'b0;
        bus.io_store = 1'b0;
        bus.io_addr  = 4'h0;
        bus.io_wdata = 8'h00;
        gpio_in      = 24'h000000;
        spi_miso     = 1'b0;
        wake_sources = 8'h00;

        // ---- reset with activity ----
        #2;
        bus.io_store = 1'b1;
        bus.io_addr  = 4'h0;
        bus.io_wdata = 8'hFF;
        gpio_in      = 24'hFFFFFF;
        wake_sources = 8'hFF;
        spi_miso     = 1'b1;
        tick(); tick();
        bus.io_store = 1'b0;
        gpio_in      = 24'h000000;
        wake_sources = 8'h00;
        spi_miso     = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_sck", 32'(spi_sck), 32'h0);
        check("rst_mosi", 32'(spi_mosi), 32'h0);
        check("rst_wake", 32'(wake), 32'h0);
        bus.io_addr = 4'h0;
        #1;
        check("rdata_no_load", 32'(bus.io_rdata), 32'h0);
        rd(4'hA, d); check("rst_status", 32'(d), 32'h00);
        rd(4'h9, d); check("rst_spi_data", 32'(d), 32'h00);
        rd(4'hC, d); check("rst_spi_div", 32'(d), 32'h00);

        // ---- GPIO ----
        tick();
        wr(4'h1, 8'hA5);
        check("gpio_out_p1", 32'(gpio_out), 32'h00A500);
        rd(4'h1, d); check("rd_gpio_out_p1", 32'(d), 32'hA5);
        wr(4'h3, 8'h77);
        rd(4'h3, d); check("rd_gpio_out_p3", 32'(d), 32'h00);
        check("gpio_out_p3_ignored", 32'(gpio_out), 32'h00A500);
        gpio_in = 24'h81003C;
        rd(4'h4, d); check("gin_0edge", 32'(d), 32'h00);
        tick();
        rd(4'h4, d); check("gin_1edge", 32'(d), 32'h00);
        tick();
        rd(4'h4, d); check("gin_2edge", 32'(d), 32'h3C);
        rd(4'h6, d); check("gin_p2", 32'(d), 32'h81);
        rd(4'h7, d); check("gin_p3_unimpl", 32'(d), 32'h00);

        // ---- SPI, divider 1 ----
        wr(4'hC, 8'h01);
        spi_miso = rx_pat[7];
        wr(4'h9, tx_pat);
        rd(4'hA, d); check("spi_busy_start", 32'(d), 32'h01);
        check("spi_mosi_first", 32'(spi_mosi), 32'h1);
        check("spi_sck_start", 32'(spi_sck), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); tick();
            check("spi_sck_rise", 32'(spi_sck), 32'h1);
            check("spi_mosi_bit", 32'(spi_mosi), 32'(tx_pat[7-i]));
            if (i < 7) spi_miso = rx_pat[6-i];
            if (i == 2) begin
                wr(4'h9, 8'hFF);
                tick();
            end else if (i == 4) begin
                wr(4'hC, 8'h05);
                tick();
            end else if (i == 7) begin
                tick();
                rd(4'hA, d); check("spi_busy_last", 32'(d), 32'h01);
                tick();
                rd(4'hA, d); check("spi_busy_fall", 32'(d), 32'h00);
            end else begin
                tick(); tick();
            end
            check("spi_sck_fall", 32'(spi_sck), 32'h0);
        end
        rd(4'h9, d); check("spi_rx_5a", 32'(d), 32'h5A);
        rd(4'hC, d); check("spi_div_busy_wr", 32'(d), 32'h01);

        // ---- SPI, divider 0, back-to-back ----
        spi_miso = 1'b0;
        wr(4'hC, 8'h00);
        wr(4'h9, 8'h00);
        check("d0_sck_lead", 32'(spi_sck), 32'h0);
        tick();
        check("d0_sck_hi", 32'(spi_sck), 32'h1);
        tick();
        check("d0_sck_lo", 32'(spi_sck), 32'h0);
        repeat (13) tick();
        rd(4'hA, d); check("d0_busy15", 32'(d), 32'h01);
        tick();
        rd(4'hA, d); check("d0_busy16", 32'(d), 32'h00);
        wr(4'h9, 8'hAB);
        rd(4'hA, d); check("b2b_busy", 32'(d), 32'h01);
        check("b2b_mosi", 32'(spi_mosi), 32'h1);
        repeat (15) tick();
        rd(4'hA, d); check("b2b_busy15", 32'(d), 32'h01);
        tick();
        rd(4'hA, d); check("b2b_busy16", 32'(d), 32'h00);
        rd(4'h9, d); check("b2b_rx", 32'(d), 32'h00);

        // ---- wake ----
        wr(4'hB, 8'h04);
        rd(4'hB, d); check("wake_mask_rd", 32'(d), 32'h04);
        wake_sources = 8'h04;
        tick(); tick();
        check("wake_sync_pre", 32'(wake), 32'h0);
        tick();
        check("wake_set", 32'(wake), 32'h1);
        wake_sources = 8'h00;
        repeat (4) tick();
        wake_sources = 8'h08;
        repeat (3) tick();
        wake_sources = 8'h00;
        repeat (3) tick();
        check("wake_hold", 32'(wake), 32'h1);
        wake_sources = 8'h04;
        tick(); tick();
        wr(4'hA, 8'h02);
        check("wake_set_wins", 32'(wake), 32'h1);
        rd(4'hA, d); check("status_wake", 32'(d), 32'h02);
        wr(4'hA, 8'h02);
        check("wake_w1c", 32'(wake), 32'h0);
        wake_sources = 8'h00;
        repeat (3) tick();
        wake_sources = 8'h08;
        repeat (3) tick();
        wake_sources = 8'h00;
        repeat (3) tick();
        check("wake_masked", 32'(wake), 32'h0);

        // ---- loopback / CTRL ----
        wr(4'hC, 8'h01);
        wr(4'h8, 8'h01);
        rd(4'h8, d); check("ctrl_rd", 32'(d), 32'(EXP_CTRL));
        spi_miso = 1'b0;
        wr(4'h9, 8'hC3);
        repeat (32) tick();
        rd(4'hA, d); check("lb_done", 32'(d), 32'h00);
        rd(4'h9, d); check("lb_rx", 32'(d), 32'(EXP_LB));

        // ---- asynchronous reset mid-transfer ----
        wr(4'h1, 8'h5C);
        wr(4'h9, 8'h55);
        tick(); tick();
        check("mid_sck_hi", 32'(spi_sck), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_sck", 32'(spi_sck), 32'h0);
        check("arst_gpio", 32'(gpio_out), 32'h0);
        rd(4'hA, d); check("arst_busy", 32'(d), 32'h00);
        #2 reset = 1'b0;
        tick();
        rd(4'hC, d); check("arst_div", 32'(d), 32'h00);
        check("arst_mosi", 32'(spi_mosi), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k12a_io_bank.md
Name: k12a_io_bank

Overview:
Parametrised next-generation memory-mapped I/O block for the K12A CPU. It provides N byte-wide GPIO output and input ports (inputs double-flop synchronised), an SPI mode-0 master with a programmable clock divider, and a maskable, edge-triggered wake latch with write-1-to-clear. It sits on the CPU I/O strobe interface (io_load/io_store/io_addr) and uses separate write and read data buses.

Parameters:
N_GPIO, 3, number of GPIO out/in byte ports (1..4)
WAKE_W, 8, number of wake source inputs (1..8)
SPI_DIV_W, 8, width of SPI divider register (1..8)

Ports:
cpu_clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
io_load  in  1  read strobe for io_addr
io_store  in  1  write strobe for io_addr
io_addr  in  4  register address
io_wdata  in  8  write data
io_rdata  out  8  read data, combinational; 0 when io_load=0
gpio_out  out  8*N_GPIO  output ports, port k at [8k+7:8k]
gpio_in  in  8*N_GPIO  asynchronous input ports
spi_sck  out  1  SPI clock, idles low
spi_mosi  out  1  SPI data out
spi_miso  in  1  SPI data in, asynchronous
wake_sources  in  WAKE_W  asynchronous wake requests
wake  out  1  wake pending

Behaviour:
- Reset (asynchronous, active-high): gpio_out=0, spi_div=0, wake_mask=0, wake_pending=0, SPI state IDLE, spi_sck=0, spi_mosi=0, rx byte=0, synchronisers=0. Reset mid-transfer aborts the transfer immediately.
- Register map: 0x0-0x3 GPIO_OUT[k], RW. 0x4-0x7 GPIO_IN[k], RO. 0x8 CTRL. 0x9 SPI_DATA. 0xA STATUS. 0xB WAKE_MASK, RW, low WAKE_W bits. 0xC SPI_DIV, RW, low SPI_DIV_W bits. Other addresses read 0 and ignore writes.
- Ports k>=N_GPIO are unimplemented: reads return 0 and writes are ignored.
- Register writes take effect at the clock edge where io_store=1. The read path is combinational from current state.
- GPIO_IN: 2-flop synchroniser per bit. A pin change becomes readable after the 2nd rising edge.
- STATUS: bit0 spi_busy (RO). bit1 wake_pending (W1C). Other bits read 0.
- Wake: wake_sources pass through a 2-flop sync plus a previous-value register. A synchronised rising edge on any bit with wake_mask=1 sets wake_pending. wake = wake_pending.
- If a set and a W1C clear occur in the same cycle, set wins.
- Mask changes do not retroactively set or clear wake_pending.
- SPI FSM states IDLE, LEAD, TRAIL; mode 0, MSB first.
- Writing SPI_DATA in IDLE loads the tx shift register and sets spi_mosi=bit7. On the next edge it enters LEAD with busy=1, spi_sck=0, and the half-period counter at 0.
- Each half-period lasts spi_div+1 cycles.
- End of LEAD half: spi_sck 0->1, sample spi_miso (2-flop synced) into rx shift.
- End of TRAIL half: spi_sck 1->0, shift tx and present the next bit on spi_mosi.
- After 8 bits the FSM returns to IDLE. busy is high for exactly 16*(spi_div+1) cycles. The rx byte is written to the SPI_DATA read register as busy falls.
- Writes to SPI_DATA or SPI_DIV while busy are ignored; SPI_DIV is sampled at transfer start.
- SPI_DATA reads return the last completed rx byte. Reads never disturb state.

Optional Feature:
K12A_IO_SPI_LOOPBACK_EN: when defined, CTRL bit0 is RW "loopback". When loopback=1, the rx path samples internal spi_mosi instead of spi_miso; pins still toggle. When undefined, CTRL reads 0, writes are ignored, and spi_miso is always used.

Test Plan:
- Reset with activity, then release -> all outputs 0, io_rdata=0; read STATUS=0x00; an assert during a transfer forces spi_sck=0 and busy=0 in the same cycle.
- N_GPIO=3: write 0xA5 to 0x1 -> gpio_out[15:8]=0xA5 next cycle, read 0x1=0xA5. Write to 0x3 -> ignored, reads 0. Set gpio_in[7:0]=0x3C -> read 0x4 returns 0x3C from 2 edges later.
- SPI_DIV=1, write SPI_DATA=0x96, spi_miso driven with 0x5A MSB-first on sck rising -> spi_mosi shows 1,0,0,1,0,1,1,0. busy is high for 32 cycles. Read SPI_DATA=0x5A. A second write at cycle 10 is ignored.
- SPI_DIV=0 -> sck period 2 cycles, busy for 16 cycles. Back-to-back transfers start the cycle after busy falls.
- WAKE_MASK=0x04, pulse wake_sources[2] -> wake=1 after sync latency. Pulse on bit 3 -> no effect. W1C 0x02 to STATUS coinciding with a new edge -> wake stays 1. Subsequent W1C -> wake=0.
- With K12A_IO_SPI_LOOPBACK_EN, CTRL=0x01, transfer 0xC3 with spi_miso held 0 -> SPI_DATA reads 0xC3. Without the macro, CTRL reads 0 and the rx byte is 0x00.
